// File: rtl/t_sync_mod_counter_pkg.sv
// rtl/t_sync_mod_counter_pkg.sv - shared constants and MODULO legality check
//
// Purpose: direction encoding, reset value and the elaboration-time legality
//          check used by the toggle-flip-flop modulo counter and its cells.
// Ports:   none (package).
package t_sync_mod_counter_pkg;

  // Encoding of the up_down input.
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Every state bit resets to zero.
  localparam int unsigned RESET_VAL = 0;

  // A counter of 'width' bits can represent 2..2**width distinct states.
  function automatic bit modulo_legal(input int width, input int modulo);
    longint unsigned span;
    span = longint'(1) << width;
    return (modulo >= 2) && (longint'(modulo) <= span);
  endfunction

endpackage

// File: rtl/t_ff_sync_cell.sv
// rtl/t_ff_sync_cell.sv - single toggle flip-flop with synchronous reset
//
// Purpose: one T flip-flop; Q toggles on the rising edge when T is 1 and
//          holds when T is 0. An X on T propagates into Q on purpose so an
//          unresolved excitation stays visible in simulation.
// Ports:   clk   - rising-edge clock
//          reset - synchronous, active-high reset (Q -> 0)
//          T     - toggle input
//          Q     - registered state
module t_ff_sync_cell
  import t_sync_mod_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic T,
  output logic Q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      Q <= 1'(RESET_VAL);
    end else begin
      Q <= Q ^ T;
    end
  end

endmodule

// File: rtl/t_sync_mod_counter.sv
// rtl/t_sync_mod_counter.sv - modulo-N up/down counter built from T flip-flops
//
// Purpose: computes the next count, turns it into a toggle vector and feeds
//          WIDTH toggle cells. Priority per edge: reset > load > en > hold.
// Ports:   clk      - rising-edge clock
//          reset    - synchronous, active-high reset
//          en       - count enable
//          up_down  - 1 = count up, 0 = count down
//          load     - synchronous parallel load of d_in
//          d_in     - load value, must be below MODULO
//          q        - registered count, 0..MODULO-1
//          t_out    - toggle vector applied at the next edge (q ^ next)
//          tc       - terminal count, high in the cycle before a wrap
//          load_err - one-cycle flag following a load of an illegal value
module t_sync_mod_counter
  import t_sync_mod_counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_out,
  output logic             tc,
  output logic             load_err
);

  if (!modulo_legal(WIDTH, MODULO)) begin : g_bad_modulo
    $fatal(1, "t_sync_mod_counter: MODULO=%0d illegal for WIDTH=%0d (need 2..2**WIDTH)",
           MODULO, WIDTH);
  end

  localparam logic [WIDTH-1:0] RST     = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] nxt;
  logic             load_bad;

  // With MODULO == 2**WIDTH, d_in <= MAX_VAL always holds and the
  // increment/decrement wrap coincides with natural overflow.
  always_comb begin
    nxt      = q;
    load_bad = 1'b0;
    if (reset) begin
      nxt = RST;
    end else if (load) begin
      if (d_in <= MAX_VAL) begin
        nxt = d_in;
      end else begin
        nxt      = RST;
        load_bad = 1'b1;
      end
    end else if (en) begin
      if (up_down == DIR_UP) begin
        nxt = (q == MAX_VAL) ? RST : q + ONE;
      end else begin
        nxt = (q == RST) ? MAX_VAL : q - ONE;
      end
    end
  end

  // Load, count and hold are all expressed as toggles; only reset writes
  // the cells directly.
  assign t_out = q ^ nxt;

  assign tc = en & ~load & ~reset &
              ((up_down == DIR_UP) ? (q == MAX_VAL) : (q == RST));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_sync_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .T     (t_out[i]),
      .Q     (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load_bad;
    end
  end

endmodule

// File: tb/tb_t_sync_mod_counter.sv
// tb/tb_t_sync_mod_counter.sv - directed self-checking bench for t_sync_mod_counter
module tb_t_sync_mod_counter;

  logic       clk = 1'b0;
  logic       reset, en, up_down, load;
  logic [3:0] d_in, q, t_out;
  logic       tc, load_err;

  // cascaded pair: units tc drives tens en
  logic       c_reset, c_en;
  logic [3:0] u_q, u_t, t_q, t_t;
  logic       u_tc, t_tc, u_le, t_le;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  t_sync_mod_counter #(.WIDTH(4), .MODULO(10)) dut (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .d_in(d_in), .q(q), .t_out(t_out), .tc(tc), .load_err(load_err)
  );

  t_sync_mod_counter #(.WIDTH(4), .MODULO(10)) u_units (
    .clk(clk), .reset(c_reset), .en(c_en), .up_down(1'b1), .load(1'b0),
    .d_in(4'd0), .q(u_q), .t_out(u_t), .tc(u_tc), .load_err(u_le)
  );

  t_sync_mod_counter #(.WIDTH(4), .MODULO(10)) u_tens (
    .clk(clk), .reset(c_reset), .en(u_tc), .up_down(1'b1), .load(1'b0),
    .d_in(4'd0), .q(t_q), .t_out(t_t), .tc(t_tc), .load_err(t_le)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_down = 1'b1; load = 1'b0; d_in = 4'd0;
    c_reset = 1'b1; c_en = 1'b0;

    // reset state
    tick;
    check("rst_q", q, 0);
    check("rst_load_err", load_err, 0);
    check("rst_tc", tc, 0);
    check("rst_t_out", t_out, 0);

    // count up 12 cycles: 0..9,0,1
    reset = 1'b0; en = 1'b1; up_down = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      check("up_q", q, i % 10);
      check("up_tc", tc, (i % 10) == 9);
      if (i == 9) check("up_t_out_at9", t_out, 4'b1001);
      if (i == 7) check("up_t_out_at7", t_out, 4'b1111);
      tick;
    end

    // back to 0, then count down 0,9,8,7
    reset = 1'b1; tick;
    reset = 1'b0; up_down = 1'b0; #1;
    check("dn_q0", q, 0);
    check("dn_tc_at0", tc, 1);
    check("dn_t_out_at0", t_out, 4'b1001);
    tick; check("dn_q9", q, 9); check("dn_tc_at9", tc, 0);
    tick; check("dn_q8", q, 8);
    tick; check("dn_q7", q, 7);

    // legal then illegal load
    en = 1'b0; load = 1'b1; d_in = 4'd6; #1;
    check("ld6_t_out", t_out, 4'b0001);
    tick;
    check("ld6_q", q, 6);
    check("ld6_load_err", load_err, 0);
    d_in = 4'd12; #1;
    check("ld12_t_out", t_out, 4'b0110);
    check("ld12_tc", tc, 0);
    tick;
    check("ld12_q", q, 0);
    check("ld12_load_err", load_err, 1);
    load = 1'b0; tick;
    check("ld12_err_clear", load_err, 0);
    check("ld12_q_hold", q, 0);

    // hold at 5, then load beats count
    load = 1'b1; d_in = 4'd5; tick;
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_t_out", t_out, 0);
      check("hold_tc", tc, 0);
      tick;
      check("hold_q", q, 5);
    end
    load = 1'b1; en = 1'b1; up_down = 1'b1; d_in = 4'd2; #1;
    check("ld_over_cnt_tc", tc, 0);
    tick;
    check("ld_over_cnt_q", q, 2);

    // reset wins over load and count at q=9
    d_in = 4'd9; tick;
    load = 1'b0; en = 1'b1; up_down = 1'b1; #1;
    check("pre_rst_q", q, 9);
    check("pre_rst_tc", tc, 1);
    reset = 1'b1; load = 1'b1; d_in = 4'd12; #1;
    check("rst_prio_tc", tc, 0);
    tick;
    check("rst_prio_q", q, 0);
    check("rst_prio_load_err", load_err, 0);
    reset = 1'b0; load = 1'b0; en = 1'b0;

    // cascaded decade counter: 00..99 then 00
    tick;
    c_reset = 1'b0; c_en = 1'b1; #1;
    check("cas_start", {t_q, u_q}, 8'h00);
    for (int k = 1; k <= 100; k++) begin
      tick;
      check("cas_units", u_q, k % 10);
      check("cas_tens", t_q, (k % 100) / 10);
      if (k == 99) check("cas_reads99", {t_q, u_q}, 8'h99);
    end
    check("cas_wrap00", {t_q, u_q}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/t_sync_mod_counter.md
Name: t_sync_mod_counter

Overview:
- Synchronous modulo-N up/down counter whose state bits are all toggle-type flip-flops.
- The block computes the T-excitation vector each cycle. Each bit toggles when its T input is 1 and holds when it is 0.
- Downstream stages consume the count. The toggle vector is also exported so other T-flip-flop stages can be driven directly.
- It is the excitation/next-state stage that feeds single toggle flip-flop cells, packaged as a complete counter.

Parameters:
- WIDTH, 4, number of state bits.
- MODULO, 10, count range 0..MODULO-1. Legal range is 2 <= MODULO <= 2**WIDTH. Elaboration fails (error message plus $finish) outside that range.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up_down  input  1  count direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load.
- d_in  input  WIDTH  load value.
- q  output  WIDTH  registered count.
- t_out  output  WIDTH  combinational T-excitation vector applied at the next edge.
- tc  output  1  combinational terminal count.
- load_err  output  1  registered one-cycle flag for an illegal load value.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). There is no asynchronous path.
- Priority at each rising edge: reset > load > en > hold.
- Reset:
  - q = 0, load_err = 0.
  - t_out and tc are evaluated from q = 0, so they are valid in the next cycle.
  - A reset asserted mid-count, or together with load or en, wins unconditionally.
- Next state (nxt):
  - load=1: nxt = d_in if d_in < MODULO. Otherwise nxt = 0 and load_err = 1 for exactly one cycle.
  - load=0, en=1, up_down=1: nxt = (q == MODULO-1) ? 0 : q+1.
  - load=0, en=1, up_down=0: nxt = (q == 0) ? MODULO-1 : q-1.
  - Otherwise: nxt = q.
- Excitation:
  - t_out = q ^ nxt. Every bit is updated as q[i] <= q[i] ^ t_out[i].
  - No direct assignment to q outside reset. Load is also realised through toggles.
- t_out = 0 whenever the next edge holds (en=0, load=0, reset=0).
- tc = en & ~load & ~reset & (up_down ? q == MODULO-1 : q == 0).
  - tc is high in the cycle before a wrap, so counters can be cascaded: the next stage's en is tied to this tc.
- load_err is registered and high only in the cycle after an illegal load. It is cleared by any other edge.
- Arithmetic:
  - All comparisons are unsigned, WIDTH bits wide.
  - The MODULO-1 constant is sized to WIDTH.
  - No intermediate value exceeds WIDTH+1 bits.
- Output q stays within 0..MODULO-1 at all times after the first reset.
- With MODULO = 2**WIDTH the wrap is natural overflow, and the illegal-load path is unreachable.
- Before the first reset, X on the T inputs must not be masked. The simulation display for an X T value is kept.

Decomposition:
- Shared include/package holds:
  - Direction constants DIR_UP = 1'b1, DIR_DN = 1'b0.
  - Reset value constant (all zeros).
  - Legality check macro for MODULO.
- One sub-module: t_ff_sync_cell.
  - Single T flip-flop, 1 bit, synchronous active-high reset, ports clk, reset, T, Q.
  - Instantiated WIDTH times by a generate loop.
  - The top level holds only the next-state, excitation, tc and load_err logic.

Test Plan:
- Reset, then en=1, up_down=1 for 12 cycles (MODULO=10) -> q goes 0,1,…,9,0,1. tc=1 only while q=9. t_out at q=9 is 4'b1001; at q=7 it is 4'b1111.
- From q=0 with en=1, up_down=0 -> q goes 9,8,7. tc=1 at q=0. t_out at q=0 is 4'b1001.
- load=1, d_in=6 -> q=6 next cycle, load_err=0. Then load=1, d_in=12 -> q=0, load_err=1 for one cycle only.
- q=5 and en=0 for 3 cycles -> q holds at 5, t_out=0, tc=0. Then load=1 with en=1, d_in=2 -> q=2 (load beats count).
- Counting up at q=9 with reset=1, load=1, en=1 in the same cycle -> q=0, load_err=0. tc is forced to 0 during reset.
- Two instances cascaded (units tc drives the tens en), up-counting from 00 for 100 cycles -> reads 99, then wraps to 00. The tens digit increments only at units 9->0.
